entrada_codigo: RTL

Parametrised keypad entry unit for the vending machine. It synchronises asynchronous key lines, detects presses, and assembles DIGITS key indices into a product code. It presents the code to the dispensing control with a valid/ack handshake. It also flags invalid entries: simultaneous presses and inter-digit timeouts.

---
 rtl/entrada_codigo_pkg.sv | 26 ++
 rtl/entrada_codigo_sinc_borda.sv | 25 ++
 rtl/entrada_codigo.sv | 132 +++++++++++++
 3 files changed

// File: rtl/entrada_codigo_pkg.sv
// Shared types and helpers for the keypad code-entry unit.
package entrada_codigo_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COLETA = 2'd1,
        PRONTO = 2'd2
    } estado_t;

    // Widest key vector the helpers accept; callers zero-extend into it.
    localparam int MAX_KEYS = 32;

    function automatic int onehot_idx(input logic [MAX_KEYS-1:0] v);
        int idx;
        idx = 0;
        for (int i = MAX_KEYS - 1; i >= 0; i--) begin
            if (v[i]) idx = i;
        end
        return idx;
    endfunction

    function automatic logic mais_de_um(input logic [MAX_KEYS-1:0] v);
        return (v & (v - MAX_KEYS'(1))) != '0;
    endfunction

endpackage

// File: rtl/entrada_codigo_sinc_borda.sv
// Two-flop synchroniser plus rising-edge detector for a single key line.
module sinc_borda (
    input  logic clk,
    input  logic rst,
    input  logic tecla_i,
    output logic borda_o
);

    logic ff1_q, ff2_q, prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ff1_q  <= 1'b0;
            ff2_q  <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            ff1_q  <= tecla_i;
            ff2_q  <= ff1_q;
            prev_q <= ff2_q;
        end
    end

    assign borda_o = ff2_q & ~prev_q;

endmodule

// File: rtl/entrada_codigo.sv
// Keypad entry: synchronises keys, assembles DIGITS key indices into a code,
// and offers it through a valid/ack handshake, flagging collisions and timeouts.
module entrada_codigo
    import entrada_codigo_pkg::*;
#(
    parameter  int N_KEYS  = 4,
    parameter  int DIGITS  = 2,
    parameter  int TIMEOUT = 50_000_000,
    localparam int DW      = $clog2(N_KEYS),
    localparam int CW      = DIGITS * DW,
    localparam int NW      = $clog2(DIGITS + 1),
    localparam int TW      = $clog2(TIMEOUT + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] teclas,
    input  logic              limpar,
    input  logic              ack,
    output logic [CW-1:0]     codigo,
    output logic              codigo_valido,
    output logic [NW-1:0]     n_digitos,
    output logic              erro,
    output logic              ocupado
);

    logic [N_KEYS-1:0] borda;

    for (genvar g = 0; g < N_KEYS; g++) begin : g_tecla
        sinc_borda u_sinc (
            .clk     (clk),
            .rst     (rst),
            .tecla_i (teclas[g]),
            .borda_o (borda[g])
        );
    end

    estado_t       estado_q, estado_d;
    logic [CW-1:0] acc_q, acc_d;
    logic [CW-1:0] codigo_q, codigo_d;
    logic          valido_q, valido_d;
    logic [NW-1:0] ndig_q, ndig_d;
    logic          erro_q, erro_d;
    logic [TW-1:0] cnt_q, cnt_d;

    logic          colisao, press;
    logic [DW-1:0] digito;
    logic [CW-1:0] acc_prox;
    logic [NW-1:0] ndig_prox;

    assign colisao   = mais_de_um(MAX_KEYS'(borda));
    assign press     = (|borda) & ~colisao;
    assign digito    = DW'(onehot_idx(MAX_KEYS'(borda)));
    // A fresh entry starts from an empty accumulator regardless of leftovers.
    assign acc_prox  = (((estado_q == IDLE) ? '0 : acc_q) << DW) | CW'(digito);
    assign ndig_prox = (estado_q == IDLE) ? NW'(1) : ndig_q + NW'(1);

    always_comb begin
        estado_d = estado_q;
        acc_d    = acc_q;
        codigo_d = codigo_q;
        valido_d = valido_q;
        ndig_d   = ndig_q;
        erro_d   = 1'b0;
        cnt_d    = cnt_q;

        if (limpar) begin
            estado_d = IDLE;
            ndig_d   = '0;
            valido_d = 1'b0;
            cnt_d    = '0;
        end else begin
            case (estado_q)
                PRONTO: begin
                    if (ack) begin
                        valido_d = 1'b0;
                        ndig_d   = '0;
                        estado_d = IDLE;
                    end
                end
                IDLE, COLETA: begin
                    if ((estado_q == COLETA && !press && cnt_q == TW'(TIMEOUT - 1)) || colisao) begin
                        erro_d   = 1'b1;
                        ndig_d   = '0;
                        cnt_d    = '0;
                        estado_d = IDLE;
                    end else if (press) begin
                        acc_d  = acc_prox;
                        ndig_d = ndig_prox;
                        cnt_d  = '0;
                        if (ndig_prox == NW'(DIGITS)) begin
                            codigo_d = acc_prox;
                            valido_d = 1'b1;
                            estado_d = PRONTO;
                        end else begin
                            estado_d = COLETA;
                        end
                    end else if (estado_q == COLETA) begin
                        cnt_d = cnt_q + TW'(1);
                    end
                end
                default: estado_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q <= IDLE;
            acc_q    <= '0;
            codigo_q <= '0;
            valido_q <= 1'b0;
            ndig_q   <= '0;
            erro_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            estado_q <= estado_d;
            acc_q    <= acc_d;
            codigo_q <= codigo_d;
            valido_q <= valido_d;
            ndig_q   <= ndig_d;
            erro_q   <= erro_d;
            cnt_q    <= cnt_d;
        end
    end

    assign codigo        = codigo_q;
    assign codigo_valido = valido_q;
    assign n_digitos     = ndig_q;
    assign erro          = erro_q;
    assign ocupado       = (estado_q != IDLE);

endmodule
